// File: rtl/dmem_wbuf_pkg.sv
// ----------------------------------------------------------------------------
// dmem_wbuf_pkg
// Shared definitions for the data-memory store buffer slice.
//   - 3-bit encodings for the bus-side FSM states
//   - the enum type that the FSM register uses, built from those encodings
//   - bus command constants for the bus_we signal
// No ports; imported by wbuf_fifo and dmem_wbuf.
// ----------------------------------------------------------------------------
package dmem_wbuf_pkg;

    // Raw 3-bit encodings, kept as localparams so other code (and
    // waveform readers) can refer to the numeric values directly.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STREQ  = 3'd1;
    localparam logic [2:0] ST_LDREQ  = 3'd2;
    localparam logic [2:0] ST_LDWAIT = 3'd3;
    localparam logic [2:0] ST_LDDONE = 3'd4;

    // Bus command polarity for bus_we.
    localparam logic WE_WRITE = 1'b1;
    localparam logic WE_READ  = 1'b0;

    // FSM state type for the bus-side controller.
    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ST_REQ  = ST_STREQ,
        LD_REQ  = ST_LDREQ,
        LD_WAIT = ST_LDWAIT,
        LD_DONE = ST_LDDONE
    } wbufState_e;

endpackage

// File: rtl/wbuf_fifo.sv
// ----------------------------------------------------------------------------
// wbuf_fifo
// DEPTH-entry FIFO holding posted stores as {word address, data}, with a
// parallel lookup port that returns the youngest entry matching an address.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset (0 = reset)
//   push_i               enqueue request (ignored when full)
//   push_addr_i/data_i   word address and data of the entry to enqueue
//   pop_i                dequeue the head entry (ignored when empty)
//   head_addr_o/data_o   oldest entry, valid whenever count_o != 0
//   count_o              number of valid entries (registered)
//   full_o               count_o == DEPTH
//   lookup_addr_i        word address to search for
//   hit_o, hit_data_o    a valid entry matches; data of the youngest match
// ----------------------------------------------------------------------------
module wbuf_fifo
    import dmem_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WAW   = 30,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WAW-1:0]             push_addr_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [WAW-1:0]             head_addr_o,
    output logic [DW-1:0]              head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    input  logic [WAW-1:0]             lookup_addr_i,
    output logic                       hit_o,
    output logic [DW-1:0]              hit_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WAW-1:0] addrMem_q [DEPTH];
    logic [DW-1:0]  dataMem_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;
    logic           doPush;
    logic           doPop;
    logic [PW-1:0]  slot;

    assign full_o      = (count_q == CW'(DEPTH));
    assign doPush      = push_i & ~full_o;
    assign doPop       = pop_i & (count_q != '0);
    assign count_o     = count_q;
    assign head_addr_o = addrMem_q[head_q];
    assign head_data_o = dataMem_q[head_q];

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap naturally. A push and a pop in the same cycle leave the
    // count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                tail_q <= tail_q + 1'b1;
            end
            if (doPop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(doPush) - CW'(doPop);
        end
    end

    // Entry storage needs no reset: only slots covered by count_q are ever
    // looked at.
    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem_q[tail_q] <= push_addr_i;
            dataMem_q[tail_q] <= push_data_i;
        end
    end

    // Walk from the oldest entry towards the youngest; a later match
    // overrides an earlier one so the youngest store wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addrMem_q[slot] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = dataMem_q[slot];
            end
        end
    end

endmodule

// File: rtl/dmem_wbuf.sv
// ----------------------------------------------------------------------------
// dmem_wbuf
// Data-memory interface between a single-cycle core and a handshaked,
// multi-cycle memory bus. Stores are posted into a FIFO and drained in
// order; loads are forwarded from the FIFO on a hit, otherwise a bus read
// is performed while the core is stalled.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   memwrite, memread          core store / load request
//   addr, wdata                core byte address and store data
//   readdata, stall            load data to core; core must hold
//   bus_req_valid/ready        request handshake
//   bus_we, bus_addr, bus_wdata request payload (word-aligned address)
//   bus_rsp_valid, bus_rdata   read response
// ----------------------------------------------------------------------------
module dmem_wbuf
    import dmem_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    output logic          bus_req_valid,
    input  logic          bus_req_ready,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_rsp_valid,
    input  logic [DW-1:0] bus_rdata
);

    localparam int WAW = AW - 2;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    wbufState_e     state_q;
    wbufState_e     state_d;
    logic [AW-1:0]  ldAddr_q;
    logic [AW-1:0]  ldAddr_d;
    logic [DW-1:0]  rdLatch_q;
    logic [DW-1:0]  rdLatch_d;

    logic           isLoad;
    logic           loadHit;
    logic           loadMiss;
    logic           storeBlocked;
    logic           stallRaw;
    logic           fifoPop;
    logic           fifoFull;
    logic           fifoHit;
    logic [CW-1:0]  fifoCount;
    logic [WAW-1:0] headAddr;
    logic [DW-1:0]  headData;
    logic [DW-1:0]  fwdData;

    // A simultaneous store and load is treated as a store only.
    assign isLoad       = memread & ~memwrite;
    assign loadHit      = isLoad & fifoHit;
    assign loadMiss     = isLoad & ~fifoHit;
    assign storeBlocked = memwrite & fifoFull;
    assign fifoPop      = (state_q == ST_REQ) & bus_req_ready;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .WAW   (WAW),
        .DW    (DW)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (memwrite),
        .push_addr_i   (addr[AW-1:2]),
        .push_data_i   (wdata),
        .pop_i         (fifoPop),
        .head_addr_o   (headAddr),
        .head_data_o   (headData),
        .count_o       (fifoCount),
        .full_o        (fifoFull),
        .lookup_addr_i (addr[AW-1:2]),
        .hit_o         (fifoHit),
        .hit_data_o    (fwdData)
    );

    // State, captured load address and read-data latch. Reset drops any
    // bus transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ldAddr_q  <= '0;
            rdLatch_q <= '0;
        end else begin
            state_q   <= state_d;
            ldAddr_q  <= ldAddr_d;
            rdLatch_q <= rdLatch_d;
        end
    end

    // Next-state and bus outputs. A load miss seen during ST_REQ keeps the
    // core stalled but waits for the write in flight to finish; back in IDLE
    // the miss takes priority over draining more stores. Bus payload is taken
    // from registered state only, so it stays stable while valid is high.
    always_comb begin
        state_d       = state_q;
        ldAddr_d      = ldAddr_q;
        rdLatch_d     = rdLatch_q;
        bus_req_valid = 1'b0;
        bus_we        = WE_READ;
        bus_addr      = '0;
        bus_wdata     = '0;
        stallRaw      = 1'b0;
        case (state_q)
            IDLE: begin
                stallRaw = loadMiss | storeBlocked;
                if (loadMiss) begin
                    state_d  = LD_REQ;
                    ldAddr_d = addr;
                end else if (fifoCount != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req_valid = 1'b1;
                bus_we        = WE_WRITE;
                bus_addr      = {headAddr, 2'b00};
                bus_wdata     = headData;
                stallRaw      = loadMiss | storeBlocked;
                if (bus_req_ready) begin
                    state_d = IDLE;
                end
            end
            LD_REQ: begin
                bus_req_valid = 1'b1;
                bus_we        = WE_READ;
                bus_addr      = ldAddr_q & WORD_MASK;
                stallRaw      = 1'b1;
                if (bus_req_ready) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                stallRaw = 1'b1;
                if (bus_rsp_valid) begin
                    rdLatch_d = bus_rdata;
                    state_d   = LD_DONE;
                end
            end
            LD_DONE: begin
                stallRaw = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The core is never held while reset is asserted.
    assign stall = reset & stallRaw;

    // In LD_DONE the latched bus data is delivered; otherwise a forwarding
    // hit wins and the latch is the idle value.
    assign readdata = (state_q == LD_DONE) ? rdLatch_q :
                      (loadHit ? fwdData : rdLatch_q);

endmodule

// File: tb/tb_dmem_wbuf.sv
// ----------------------------------------------------------------------------
// tb_dmem_wbuf
// Directed testbench for dmem_wbuf: reset, store drain, full buffer,
// forwarding, load miss and reset in the middle of a bus read.
// ----------------------------------------------------------------------------
module tb_dmem_wbuf;
    import dmem_wbuf_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } busTxn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite;
    logic          memread;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] readdata;
    logic          stall;
    logic          bus_req_valid;
    logic          bus_req_ready;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_rsp_valid;
    logic [DW-1:0] bus_rdata;

    busTxn_t       busLog[$];
    int            checks = 0;
    int            errors = 0;
    int            base;

    logic [31:0]   drainAddr [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0]   drainData [3] = '{32'hA, 32'hB, 32'hC};

    dmem_wbuf #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memwrite      (memwrite),
        .memread       (memread),
        .addr          (addr),
        .wdata         (wdata),
        .readdata      (readdata),
        .stall         (stall),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    // Record every accepted bus request, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && bus_req_valid && bus_req_ready) begin
            busLog.push_back({bus_we, bus_addr, bus_wdata});
        end
    end

    task automatic applyStimulus(input logic mw, input logic mr,
                                 input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input logic rdy, input logic rv,
                                 input logic [DW-1:0] rd);
        memwrite      = mw;
        memread       = mr;
        addr          = a;
        wdata         = wd;
        bus_req_ready = rdy;
        bus_rsp_valid = rv;
        bus_rdata     = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Step until the buffer is empty and the FSM is idle, within a budget.
    task automatic waitIdle(input string tag, input logic rdy);
        int n = 0;
        applyStimulus(1'b0, 1'b0, '0, '0, rdy, 1'b0, '0);
        while (!(dut.state_q == IDLE && dut.u_fifo.count_o == '0) && n < 50) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, {31'd0, (dut.state_q == IDLE && dut.u_fifo.count_o == '0)}, 32'd1);
    endtask

    initial begin
        // Reset held for two edges with random inputs.
        reset = 1'b0;
        applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom,
                      1'($urandom), 1'($urandom), $urandom);
        nextCycle();
        applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom,
                      1'($urandom), 1'($urandom), $urandom);
        nextCycle();
        sample();
        checkOutput("rstStall", {31'd0, stall}, 32'd0);
        checkOutput("rstValid", {31'd0, bus_req_valid}, 32'd0);
        checkOutput("rstWe", {31'd0, bus_we}, 32'd0);
        checkOutput("rstBusAddr", bus_addr, 32'd0);
        checkOutput("rstBusWdata", bus_wdata, 32'd0);
        checkOutput("rstReaddata", readdata, 32'd0);
        checkOutput("rstCount", 32'(dut.u_fifo.count_o), 32'd0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        nextCycle();

        // Store drain: three stores with ready high.
        base = busLog.size();
        applyStimulus(1'b1, 1'b0, 32'h100, 32'hA, 1'b1, 1'b0, '0);
        sample();
        checkOutput("drainStall0", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h104, 32'hB, 1'b1, 1'b0, '0);
        sample();
        checkOutput("drainStall1", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h108, 32'hC, 1'b1, 1'b0, '0);
        sample();
        checkOutput("drainStall2", {31'd0, stall}, 32'd0);
        checkOutput("drainValid", {31'd0, bus_req_valid}, 32'd1);
        nextCycle();
        waitIdle("drainDone", 1'b1);
        checkOutput("drainCount", busLog.size() - base, 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (busLog.size() > base + k) begin
                checkOutput($sformatf("drainWe%0d", k), {31'd0, busLog[base+k].we}, 32'd1);
                checkOutput($sformatf("drainAddr%0d", k), busLog[base+k].a, drainAddr[k]);
                checkOutput($sformatf("drainData%0d", k), busLog[base+k].d, drainData[k]);
            end
        end

        // Full buffer: five stores with ready low.
        nextCycle();
        base = busLog.size();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h10 + 32'(4 * k), 32'(k + 1), 1'b0, 1'b0, '0);
            sample();
            checkOutput($sformatf("fullStall%0d", k), {31'd0, stall}, 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5, 1'b0, 1'b0, '0);
        sample();
        checkOutput("fullStall4", {31'd0, stall}, 32'd1);
        checkOutput("fullCount4", 32'(dut.u_fifo.count_o), 32'd4);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5, 1'b1, 1'b0, '0);
        sample();
        checkOutput("fullStallPop", {31'd0, stall}, 32'd1);
        checkOutput("fullHeadAddr", bus_addr, 32'h10);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h5, 1'b0, 1'b0, '0);
        sample();
        checkOutput("fullStallFree", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        sample();
        checkOutput("fullCountAfter", 32'(dut.u_fifo.count_o), 32'd4);
        nextCycle();
        waitIdle("fullDone", 1'b1);
        checkOutput("fullTxns", busLog.size() - base, 32'd5);
        if (busLog.size() >= base + 5) begin
            checkOutput("fullFirstAddr", busLog[base].a, 32'h10);
            checkOutput("fullLastAddr", busLog[base+4].a, 32'h20);
            checkOutput("fullLastData", busLog[base+4].d, 32'h5);
        end

        // Forwarding: two stores to the same word, youngest wins.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h11, 1'b0, 1'b0, '0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h22, 1'b0, 1'b0, '0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h202, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        sample();
        checkOutput("fwdData", readdata, 32'h22);
        checkOutput("fwdStall", {31'd0, stall}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h204, '0, 1'b0, 1'b0, '0);
        sample();
        checkOutput("fwdMissStall", {31'd0, stall}, 32'd1);
        nextCycle();
        waitIdle("fwdDone", 1'b1);

        // Load miss on an empty buffer.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h300, '0, 1'b1, 1'b0, '0);
        sample();
        checkOutput("missStall1", {31'd0, stall}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h300, '0, 1'b1, 1'b1, 32'hBAD0_BAD0);
        sample();
        checkOutput("missStall2", {31'd0, stall}, 32'd1);
        checkOutput("missReqValid", {31'd0, bus_req_valid}, 32'd1);
        checkOutput("missReqWe", {31'd0, bus_we}, 32'd0);
        checkOutput("missReqAddr", bus_addr, 32'h300);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h300, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        sample();
        checkOutput("missStall3", {31'd0, stall}, 32'd1);
        checkOutput("missWaitValid", {31'd0, bus_req_valid}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h300, '0, 1'b1, 1'b0, '0);
        sample();
        checkOutput("missStall4", {31'd0, stall}, 32'd0);
        checkOutput("missData", readdata, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        sample();
        checkOutput("missLatchHold", readdata, 32'hDEAD_BEEF);
        nextCycle();

        // Reset during LD_WAIT with two stores still buffered.
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h1, 1'b1, 1'b0, '0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h404, 32'h2, 1'b1, 1'b0, '0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h408, 32'h3, 1'b1, 1'b0, '0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h3A2, '0, 1'b1, 1'b0, '0);
        sample();
        checkOutput("rmStallIdle", {31'd0, stall}, 32'd1);
        nextCycle();
        sample();
        checkOutput("rmReqAddr", bus_addr, 32'h3A0);
        checkOutput("rmReqWe", {31'd0, bus_we}, 32'd0);
        nextCycle();
        sample();
        checkOutput("rmStateWait", 32'(dut.state_q), 32'(ST_LDWAIT));
        checkOutput("rmCountWait", 32'(dut.u_fifo.count_o), 32'd2);
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h55);
        sample();
        checkOutput("rmStateIdle", 32'(dut.state_q), 32'(ST_IDLE));
        checkOutput("rmValid", {31'd0, bus_req_valid}, 32'd0);
        checkOutput("rmCount", 32'(dut.u_fifo.count_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        sample();
        checkOutput("rmLateRsp", readdata, 32'd0);
        checkOutput("rmStillIdle", 32'(dut.state_q), 32'(ST_IDLE));
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory interface between the single-cycle core's data port (memwrite, aluout, writedata, readdata) and a handshaked, multi-cycle memory bus.
- Stores are posted into a DEPTH-entry FIFO store buffer and drained to the bus in order.
- Loads are forwarded from the buffer on an address hit; otherwise the block performs a bus read and raises stall until the data returns.

Parameters:
DEPTH, 4, store-buffer entries (power of two, >=2)
DW, 32, data width
AW, 32, byte-address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
memwrite  input  1  core store request
memread  input  1  core load request (driven from memtoreg)
addr  input  AW  core byte address (aluout)
wdata  input  DW  store data (writedata)
readdata  output  DW  load data to core
stall  output  1  core must hold its current instruction
bus_req_valid  output  1  bus request valid
bus_req_ready  input  1  bus accepts request
bus_we  output  1  1 = write, 0 = read
bus_addr  output  AW  word address, bits [1:0] forced to 00
bus_wdata  output  DW  write data
bus_rsp_valid  input  1  read data valid
bus_rdata  input  DW  read data

Behaviour:
- Reset is sampled at posedge clk while reset==0:
  - buffer emptied; count=0; state=IDLE.
  - bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - readdata latch=0; stall=0.
- Reset mid-transaction abandons the bus request or read in flight. Buffered stores are lost.
- Word addressing: all compares use addr[AW-1:2]; addr[1:0] are ignored.
- Store path:
  - memwrite=1 and count<DEPTH: entry {word addr, wdata} enqueued at the clock edge; stall=0.
  - memwrite=1 and count==DEPTH: stall=1 and no enqueue. The full test uses the registered count; a same-cycle pop does not free a slot.
  - memwrite and memread both 1: treated as a store; memread is ignored.
- Load hit:
  - memread=1 with one or more valid entries matching: readdata = data of the youngest match, combinationally; stall=0.
- Load miss:
  - stall=1 combinationally from the first cycle.
  - The miss is serviced by the FSM. readdata comes from the latch in LD_DONE.
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT, LD_DONE.
  - IDLE: load miss -> LD_REQ; else count>0 -> ST_REQ; else stay. Bus outputs idle (valid=0).
  - ST_REQ: valid=1, we=1, addr/wdata = head entry, held stable. On ready: pop head -> IDLE.
  - LD_REQ: valid=1, we=0, addr = load word address. On ready -> LD_WAIT.
  - LD_WAIT: valid=0. On rsp_valid: latch bus_rdata -> LD_DONE.
  - LD_DONE: readdata=latch, stall=0 for exactly this cycle -> IDLE.
- Bus rules:
  - Once asserted, valid stays 1 with stable payload until ready.
  - rsp_valid is ignored outside LD_WAIT.
  - Only one request is outstanding at a time.
- Load priority:
  - A load miss waits for any ST_REQ already issued to complete, then wins over further drains.
  - A load miss cannot hit a store enqueued later, because the core is stalled.
- Ordering and latency:
  - Stores reach the bus in program order.
  - A load miss to an address not in the buffer may bypass older buffered stores.
  - Minimum miss latency with ready=1 and rsp_valid one cycle after acceptance: stall for 3 cycles (IDLE, LD_REQ, LD_WAIT); data delivered in the 4th cycle (LD_DONE).
- Default readdata when there is no load: latch value.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams ST_IDLE..ST_LDDONE) and the bus command constants (WE_WRITE=1, WE_READ=0).
- One sub-module: wbuf_fifo, the DEPTH-deep FIFO with head/tail pointers, count, and a parallel youngest-match forward-lookup port.
- The FSM and bus muxing stay in dmem_wbuf.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> stall=0, bus_req_valid=0, readdata=0, buffer empty.
- Store drain: 3 stores (0x100<-0xA, 0x104<-0xB, 0x108<-0xC) with ready=1 -> stall stays 0; three bus writes appear in that order with bus_we=1 and matching addr/data.
- Full: ready=0, 5 stores with DEPTH=4 -> stall=1 on the 5th only; after one ready pulse, the 5th enqueues the following cycle and stall falls.
- Forwarding: store 0x200<-0x11, then 0x200<-0x22 (ready=0), then load 0x202 -> readdata=0x22 in the same cycle with stall=0.
- Load miss: empty buffer, load 0x300, ready=1, rsp_valid one cycle later with rdata 0xDEADBEEF -> stall=1 for 3 cycles; readdata=0xDEADBEEF with stall=0 on the 4th cycle.
- Reset mid-operation: assert reset=0 during LD_WAIT with 2 buffered stores -> next cycle state IDLE, bus_req_valid=0, count=0; a late rsp_valid is ignored.
